// File: rtl/c2f_req_arb.sv
// Purpose: buffers one memory request per GPC thread, issues them round-robin onto the C2F ring, routes RD_RSP back to the owning thread.
// Latency: thread request valid in cycle c -> ring request valid in c+2; ring response in n -> thread return in n+1.
// Backpressure: a thread is ready only with its buffer empty and no read pending; C2F_RspStall freezes issue and keeps buffers.
package c2f_req_arb_pkg;
    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;

    typedef struct packed {
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_reqEntry;
endpackage

module c2f_req_arb
    import c2f_req_arb_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int TID_W       = 2
) (
    input  logic                              QClk,
    input  logic                              RstQnnnH,
    input  logic [NUM_THREADS-1:0]            ThrReqValidQ103H,
    input  t_opcode [NUM_THREADS-1:0]         ThrReqOpcodeQ103H,
    input  logic [NUM_THREADS-1:0][31:0]      ThrReqAddressQ103H,
    input  logic [NUM_THREADS-1:0][31:0]      ThrReqDataQ103H,
    output logic [NUM_THREADS-1:0]            ThrReqReadyQnnnH,
    output logic [NUM_THREADS-1:0]            ThrRdPendQnnnH,
    output logic                              C2F_ReqValidQ500H,
    output t_opcode                           C2F_ReqOpcodeQ500H,
    output logic [TID_W-1:0]                  C2F_ReqThreadIDQ500H,
    output logic [31:0]                       C2F_ReqAddressQ500H,
    output logic [31:0]                       C2F_ReqDataQ500H,
    input  logic                              C2F_RspStall,
    input  logic                              C2F_RspValidQ502H,
    input  t_opcode                           C2F_RspOpcodeQ502H,
    input  logic [TID_W-1:0]                  C2F_RspThreadIDQ502H,
    input  logic [31:0]                       C2F_RspDataQ502H,
    output logic [NUM_THREADS-1:0]            ThrRspValidQ503H,
    output logic [31:0]                       ThrRspDataQ503H,
    output logic                              SpurRspQnnnH
);

    t_reqEntry [NUM_THREADS-1:0] reqBuf;
    logic [NUM_THREADS-1:0]      bufValid;
    logic [NUM_THREADS-1:0]      rdPend;
    logic [NUM_THREADS-1:0]      reqAccept;
    logic [TID_W-1:0]            rrPtr;
    logic [TID_W-1:0]            cand;
    logic [TID_W-1:0]            winTid;
    logic                        winVld;
    logic                        rspMatch;

    // Ready depends on registered state only, so a thread can never refill in the cycle its read returns.
    assign ThrReqReadyQnnnH = ~bufValid & ~rdPend;
    assign ThrRdPendQnnnH   = rdPend;
    assign reqAccept        = ThrReqValidQ103H & ThrReqReadyQnnnH;
    assign rspMatch         = C2F_RspValidQ502H && (C2F_RspOpcodeQ502H == RD_RSP)
                              && rdPend[C2F_RspThreadIDQ502H];

    // Round-robin pick: first buffered thread searching upward from the last winner, suppressed by stall.
    always_comb begin
        winVld = 1'b0;
        winTid = '0;
        cand   = '0;
        if (!C2F_RspStall) begin
            for (int i = 1; i <= NUM_THREADS; i++) begin
                cand = rrPtr + TID_W'(i);
                if (!winVld && bufValid[cand]) begin
                    winVld = 1'b1;
                    winTid = cand;
                end
            end
        end
    end

    // Per-thread single-entry buffers: fill on accept, drain on grant (never both for one thread).
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            bufValid <= '0;
            reqBuf   <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (reqAccept[t]) begin
                    bufValid[t] <= 1'b1;
                    reqBuf[t]   <= '{opcode:  ThrReqOpcodeQ103H[t],
                                     address: ThrReqAddressQ103H[t],
                                     data:    ThrReqDataQ103H[t]};
                end else if (winVld && (winTid == TID_W'(t))) begin
                    bufValid[t] <= 1'b0;
                end
            end
        end
    end

    // Outstanding-read tracking: set when a read is granted, cleared by its matching RD_RSP.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            rdPend <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (winVld && (winTid == TID_W'(t)) && (reqBuf[t].opcode == RD)) begin
                    rdPend[t] <= 1'b1;
                end else if (rspMatch && (C2F_RspThreadIDQ502H == TID_W'(t))) begin
                    rdPend[t] <= 1'b0;
                end
            end
        end
    end

    // Ring request registers and round-robin pointer; pointer starts at the top so thread 0 wins first.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            rrPtr                <= TID_W'(NUM_THREADS - 1);
            C2F_ReqValidQ500H    <= 1'b0;
            C2F_ReqOpcodeQ500H   <= RD;
            C2F_ReqThreadIDQ500H <= '0;
            C2F_ReqAddressQ500H  <= '0;
            C2F_ReqDataQ500H     <= '0;
        end else begin
            C2F_ReqValidQ500H <= winVld;
            if (winVld) begin
                rrPtr                <= winTid;
                C2F_ReqOpcodeQ500H   <= reqBuf[winTid].opcode;
                C2F_ReqThreadIDQ500H <= winTid;
                C2F_ReqAddressQ500H  <= reqBuf[winTid].address;
                C2F_ReqDataQ500H     <= reqBuf[winTid].data;
            end
        end
    end

    // Response return to the owning thread, plus a sticky flag for responses nobody was waiting for.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            ThrRspValidQ503H <= '0;
            ThrRspDataQ503H  <= '0;
            SpurRspQnnnH     <= 1'b0;
        end else begin
            ThrRspValidQ503H <= rspMatch ? (NUM_THREADS'(1) << C2F_RspThreadIDQ502H) : '0;
            if (rspMatch) begin
                ThrRspDataQ503H <= C2F_RspDataQ502H;
            end
            if (C2F_RspValidQ502H && !rspMatch) begin
                SpurRspQnnnH <= 1'b1;
            end
        end
    end

endmodule
